rng_arbiter: RTL and testbench

Round-robin arbiter that shares one 7-bit maximal-length LFSR noise source between NREQ requesters in the voice-alteration datapath, such as the pitch-jitter, dither and noise-mix stages. Each granted request advances the LFSR by exactly one step on the system clock, with no gated or derived clock edges. The winner receives the fresh value with a one-cycle acknowledge, so no two requesters ever receive the same sample. A synchronous seed-load port lets the control path restart the sequence at a known point.

---
 rtl/rng_pkg.sv | 24 ++
 rtl/rr_pick.sv | 35 +++
 rtl/rng_arbiter.sv | 89 ++++++++
 tb/tb_rng_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and helpers for the LFSR noise-source arbiter.
// Holds the 7-bit LFSR step function, the seed sanitiser and the FSM encoding.
package rng_pkg;

    localparam int LFSR_W = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 7'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_t;

    // x^7+x+1: the shift moves every bit up one place and the new bit 1 is bit 1 xor bit 7.
    function automatic logic [LFSR_W-1:0] lfsr7_next(input logic [LFSR_W-1:0] sreg);
        return {sreg[LFSR_W-2:0], sreg[0] ^ sreg[LFSR_W-1]};
    endfunction

    // The all-zero state would lock the LFSR, so it is replaced by the default seed.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? LFSR_SEED_DEFAULT : seed;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request at or above ptr,
// wrapping at NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any_req
);

    logic [PW:0]   pos;
    logic [PW-1:0] idx;

    // Walk the offsets downward so the smallest offset from ptr is the last one written.
    always_comb begin
        winner = '0;
        pos    = '0;
        idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (PW+1)'(i);
            if (pos >= (PW+1)'(NREQ)) begin
                pos = pos - (PW+1)'(NREQ);
            end
            idx = pos[PW-1:0];
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 7-bit maximal-length LFSR between NREQ requesters;
// every grant advances the LFSR one step and hands the fresh value to the winner only.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int                NREQ = 4,
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rnd,
    output logic              busy,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in
);

    localparam int PW = $clog2(NREQ);
    localparam logic [LFSR_W-1:0] SEED_EFF = seed_fix(SEED);

    state_t            state;
    logic [LFSR_W-1:0] sreg;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     pick;
    logic              any_req;
    logic [LFSR_W-1:0] seed_val;
    logic [LFSR_W-1:0] step_val;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (pick),
        .any_req (any_req)
    );

    assign seed_val = seed_fix(seed_in);
    assign step_val = lfsr7_next(sreg);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sreg  <= SEED_EFF;
            ptr   <= '0;
            win   <= '0;
            ack   <= '0;
            rnd   <= 8'h00;
            busy  <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win   <= pick;
                        busy  <= 1'b1;
                        state <= STEP;
                    end
                end
                STEP: begin
                    // ack and rnd are registered here so they are visible throughout GRANT.
                    ack   <= NREQ'(1) << win;
                    rnd   <= {1'b0, (seed_load ? seed_val : step_val)};
                    state <= GRANT;
                end
                GRANT: begin
                    ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // A seed load overrides the step that would otherwise happen in STEP.
            if (seed_load) begin
                sreg <= seed_val;
            end else if (state == STEP) begin
                sreg <= step_val;
            end
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter: latency, full LFSR period, round-robin order,
// wrap-around, seed loading and asynchronous reset during a grant.
module tb_rng_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] ack;
    logic [7:0] rnd;
    logic       busy;
    logic       seed_load = 1'b0;
    logic [6:0] seed_in = 7'h00;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    rng_arbiter #(
        .NREQ (4),
        .SEED (7'h01)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .ack       (ack),
        .rnd       (rnd),
        .busy      (busy),
        .seed_load (seed_load),
        .seed_in   (seed_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for an ack; returns the number of falling edges it took.
    task automatic wait_ack(output int cycles, output logic ok);
        cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            cycles++;
            if (ack !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic grant1(input logic [3:0] r, input logic [3:0] exp_ack,
                          input logic check_rnd, input logic [7:0] exp_rnd,
                          input string tag, output logic [7:0] got);
        int   cyc;
        logic ok;
        req = r;
        wait_ack(cyc, ok);
        chk({tag, "_seen"}, 32'(ok), 32'd1);
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        if (check_rnd) chk({tag, "_rnd"}, 32'(rnd), 32'(exp_rnd));
        got = rnd;
        $display("grant %s req=%b ack=%b rnd=%h cycles=%0d", tag, r, ack, rnd, cyc);
        req = 4'b0000;
        @(negedge clock);
    endtask

    initial begin
        logic [7:0]   got;
        logic [127:0] seen;
        int           dups;
        logic [7:0]   p1, p2;
        logic         saw_run;
        logic [7:0]   rv [4];
        logic [3:0]   exp_order [4];
        int           cyc;
        logic         ok;
        int           distinct;
        logic         any_ack;

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_rnd", 32'(rnd), 32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // Latency: req seen at edge k, ack visible after edge k+1, gone after edge k+2.
        req = 4'b0001;
        @(negedge clock);
        chk("lat_busy", 32'(busy), 32'h1);
        chk("lat_noack", 32'(ack), 32'h0);
        @(negedge clock);
        chk("lat_ack", 32'(ack), 32'h1);
        chk("lat_rnd", 32'(rnd), 32'h03);
        $display("grant lat req=0001 ack=%b rnd=%h", ack, rnd);
        req = 4'b0000;
        @(negedge clock);
        chk("pulse_ack", 32'(ack), 32'h0);
        chk("hold_rnd", 32'(rnd), 32'h03);
        chk("idle_busy", 32'(busy), 32'h0);

        grant1(4'b0001, 4'b0001, 1'b1, 8'h07, "g2", got);
        grant1(4'b0001, 4'b0001, 1'b1, 8'h0F, "g3", got);
        grant1(4'b0001, 4'b0001, 1'b1, 8'h1F, "g4", got);

        // Full period from seed 7'h01.
        seed_in = 7'h01;
        seed_load = 1'b1;
        @(negedge clock);
        seed_load = 1'b0;
        seen = '0;
        dups = 0;
        p1 = 8'h00;
        p2 = 8'h00;
        saw_run = 1'b0;
        for (int g = 1; g <= 127; g++) begin
            grant1(4'b0001, 4'b0001, 1'b0, 8'h00, $sformatf("per%0d", g), got);
            if (got[7] !== 1'b0 || got == 8'h00) dups++;
            else if (seen[got[6:0]]) dups++;
            else seen[got[6:0]] = 1'b1;
            if (p2 == 8'h7F && p1 == 8'h7E && got == 8'h7D) saw_run = 1'b1;
            p2 = p1;
            p1 = got;
            if (g == 127) chk("period_wrap", 32'(got), 32'h01);
        end
        chk("period_dups", 32'(dups), 32'd0);
        chk("period_cover", 32'(&seen[127:1]), 32'h1);
        chk("period_run", 32'(saw_run), 32'h1);

        // Bring ptr to 0 with a grant to requester 3.
        grant1(4'b1000, 4'b1000, 1'b1, 8'h03, "to_ptr0", got);

        // All four requesting: strict rotation, one grant every 3 cycles.
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(cyc, ok);
            chk($sformatf("rr%0d_seen", i), 32'(ok), 32'd1);
            chk($sformatf("rr%0d_ack", i), 32'(ack), 32'(exp_order[i]));
            if (i > 0) chk($sformatf("rr%0d_gap", i), 32'(cyc), 32'd3);
            rv[i] = rnd;
            $display("grant rr%0d req=%b ack=%b rnd=%h cycles=%0d", i, req, ack, rnd, cyc);
            req = req & ~ack;
        end
        distinct = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (rv[i] !== rv[j]) distinct++;
        chk("rr_distinct", 32'(distinct), 32'd6);
        @(negedge clock);

        // ptr = 2 after a grant to requester 1, then requesters 0 and 1 compete.
        grant1(4'b0010, 4'b0010, 1'b1, 8'h7F, "to_ptr2", got);
        req = 4'b0011;
        wait_ack(cyc, ok);
        chk("wrap0_ack", 32'(ack), 32'h1);
        chk("wrap0_rnd", 32'(rnd), 32'h7E);
        $display("grant wrap0 ack=%b rnd=%h", ack, rnd);
        req = req & ~ack;
        wait_ack(cyc, ok);
        chk("wrap1_ack", 32'(ack), 32'h2);
        chk("wrap1_rnd", 32'(rnd), 32'h7D);
        $display("grant wrap1 ack=%b rnd=%h", ack, rnd);
        req = 4'b0000;
        @(negedge clock);

        // Zero seed is replaced by 7'h01.
        seed_in = 7'h00;
        seed_load = 1'b1;
        @(negedge clock);
        seed_load = 1'b0;
        grant1(4'b0001, 4'b0001, 1'b1, 8'h03, "seed0", got);

        // Seed load in the STEP cycle delivers the seed itself.
        req = 4'b0001;
        @(negedge clock);
        chk("seed55_busy", 32'(busy), 32'h1);
        seed_in = 7'h55;
        seed_load = 1'b1;
        @(negedge clock);
        seed_load = 1'b0;
        chk("seed55_ack", 32'(ack), 32'h1);
        chk("seed55_rnd", 32'(rnd), 32'h55);
        $display("grant seed55 ack=%b rnd=%h", ack, rnd);
        req = 4'b0000;
        @(negedge clock);
        grant1(4'b0001, 4'b0001, 1'b1, 8'h2A, "after55", got);

        // Asynchronous reset during STEP drops the grant.
        req = 4'b0001;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rnd", 32'(rnd), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        req = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
        any_ack = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (ack !== 4'b0000) any_ack = 1'b1;
        end
        chk("rst_dropped", 32'(any_ack), 32'h0);
        grant1(4'b0001, 4'b0001, 1'b1, 8'h03, "post_rst", got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
